// File: rtl/gpu_seq_pkg.sv
// Shared opcodes, FSM state encoding and the default-width draw command layout
// for the draw sequencer.
package gpu_seq_pkg;

    localparam int unsigned DEF_WIDTH_BITS   = 10;
    localparam int unsigned DEF_HEIGHT_BITS  = 9;
    localparam int unsigned DEF_CHANNEL_BITS = 8;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;

    localparam logic [3:0] OP_RESET     = 4'b0000;
    localparam logic [3:0] OP_SET_XY1   = 4'b0001;
    localparam logic [3:0] OP_SET_XY2   = 4'b0010;
    localparam logic [3:0] OP_SET_RAD   = 4'b0011;
    localparam logic [3:0] OP_DRAW_LINE = 4'b0100;
    localparam logic [3:0] OP_DRAW_RECT = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    // 73 bits with the default field widths
    typedef struct packed {
        logic                        op;
        logic [DEF_WIDTH_BITS-1:0]   x1;
        logic [DEF_HEIGHT_BITS-1:0]  y1;
        logic [DEF_WIDTH_BITS-1:0]   x2;
        logic [DEF_HEIGHT_BITS-1:0]  y2;
        logic [DEF_WIDTH_BITS-1:0]   rad;
        logic [DEF_CHANNEL_BITS-1:0] r;
        logic [DEF_CHANNEL_BITS-1:0] g;
        logic [DEF_CHANNEL_BITS-1:0] b;
    } draw_cmd_t;

    function automatic logic is_draw_op(input logic [3:0] op);
        return (op == OP_DRAW_LINE) || (op == OP_DRAW_RECT);
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO with flush; a push while full is accepted only
// when a pop happens in the same cycle.
module gpu_cmd_fifo #(
    parameter int unsigned DATA_W = 73,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gpu_draw_sequencer.sv
// Shadows draw parameters from the decoder, queues complete draw commands and
// hands them one at a time to the draw engine.
module gpu_draw_sequencer
    import gpu_seq_pkg::*;
#(
    parameter int unsigned WIDTH_BITS   = DEF_WIDTH_BITS,
    parameter int unsigned HEIGHT_BITS  = DEF_HEIGHT_BITS,
    parameter int unsigned CHANNEL_BITS = DEF_CHANNEL_BITS,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          command_i,
    input  logic [3:0]                    opcode_i,
    input  logic                          write_enable_i,
    input  logic                          push_instr_i,
    input  logic [WIDTH_BITS-1:0]         x1_i,
    input  logic [WIDTH_BITS-1:0]         x2_i,
    input  logic [HEIGHT_BITS-1:0]        y1_i,
    input  logic [HEIGHT_BITS-1:0]        y2_i,
    input  logic [WIDTH_BITS-1:0]         rad_i,
    input  logic [CHANNEL_BITS-1:0]       r_i,
    input  logic [CHANNEL_BITS-1:0]       g_i,
    input  logic [CHANNEL_BITS-1:0]       b_i,
    output logic                          draw_valid_o,
    input  logic                          draw_ready_i,
    output logic                          draw_op_o,
    output logic [WIDTH_BITS-1:0]         draw_x1_o,
    output logic [WIDTH_BITS-1:0]         draw_x2_o,
    output logic [HEIGHT_BITS-1:0]        draw_y1_o,
    output logic [HEIGHT_BITS-1:0]        draw_y2_o,
    output logic [WIDTH_BITS-1:0]         draw_rad_o,
    output logic [CHANNEL_BITS-1:0]       draw_r_o,
    output logic [CHANNEL_BITS-1:0]       draw_g_o,
    output logic [CHANNEL_BITS-1:0]       draw_b_o,
    input  logic                          engine_done_i,
    output logic                          engine_abort_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic                          idle_o
);

    typedef struct packed {
        logic                    op;
        logic [WIDTH_BITS-1:0]   x1;
        logic [HEIGHT_BITS-1:0]  y1;
        logic [WIDTH_BITS-1:0]   x2;
        logic [HEIGHT_BITS-1:0]  y2;
        logic [WIDTH_BITS-1:0]   rad;
        logic [CHANNEL_BITS-1:0] r;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] b;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    state_e                  state_q, state_d;
    logic [WIDTH_BITS-1:0]   x1_q, x1_d, x2_q, x2_d, rad_q, rad_d;
    logic [HEIGHT_BITS-1:0]  y1_q, y1_d, y2_q, y2_d;
    logic                    overflow_q, overflow_d;
    logic                    abort_q, abort_d;

    logic                    soft_clear;
    logic                    capture;
    logic                    push_req;
    logic                    pop_req;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CMD_W-1:0]        fifo_rdata;
    cmd_t                    wcmd;
    cmd_t                    head;

    assign soft_clear = command_i && (opcode_i == OP_RESET);
    assign capture    = command_i && write_enable_i;
    assign push_req   = command_i && push_instr_i && is_draw_op(opcode_i);
    // A ready arriving together with a soft clear must not consume an entry.
    assign pop_req    = (state_q == ST_LAUNCH) && draw_ready_i && !soft_clear;

    always_comb begin
        wcmd     = '0;
        wcmd.op  = opcode_i[0];
        wcmd.x1  = x1_q;
        wcmd.y1  = y1_q;
        wcmd.x2  = x2_q;
        wcmd.y2  = y2_q;
        wcmd.rad = rad_q;
        wcmd.r   = r_i;
        wcmd.g   = g_i;
        wcmd.b   = b_i;
    end

    gpu_cmd_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (soft_clear),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .wdata_i (wcmd),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    always_comb begin
        x1_d       = x1_q;
        y1_d       = y1_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        rad_d      = rad_q;
        overflow_d = overflow_q;
        state_d    = state_q;
        abort_d    = soft_clear && (state_q != ST_IDLE);

        if (soft_clear) begin
            x1_d       = '0;
            y1_d       = '0;
            x2_d       = '0;
            y2_d       = '0;
            rad_d      = '0;
            overflow_d = 1'b0;
            state_d    = ST_IDLE;
        end else begin
            if (capture) begin
                case (opcode_i)
                    OP_SET_XY1: begin x1_d = x1_i; y1_d = y1_i; end
                    OP_SET_XY2: begin x2_d = x2_i; y2_d = y2_i; end
                    OP_SET_RAD: rad_d = rad_i;
                    default: ;
                endcase
            end
            if (push_req && fifo_full && !pop_req) overflow_d = 1'b1;

            case (state_q)
                ST_IDLE:   if (!fifo_empty) state_d = ST_LAUNCH;
                ST_LAUNCH: if (draw_ready_i) state_d = ST_WAIT;
                ST_WAIT:   if (engine_done_i) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            rad_q      <= '0;
            overflow_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            rad_q      <= rad_d;
            overflow_q <= overflow_d;
            abort_q    <= abort_d;
        end
    end

    assign head           = fifo_empty ? cmd_t'('0) : cmd_t'(fifo_rdata);
    assign draw_valid_o   = (state_q == ST_LAUNCH);
    assign draw_op_o      = head.op;
    assign draw_x1_o      = head.x1;
    assign draw_y1_o      = head.y1;
    assign draw_x2_o      = head.x2;
    assign draw_y2_o      = head.y2;
    assign draw_rad_o     = head.rad;
    assign draw_r_o       = head.r;
    assign draw_g_o       = head.g;
    assign draw_b_o       = head.b;
    assign engine_abort_o = abort_q;
    assign overflow_o     = overflow_q;
    assign idle_o         = (state_q == ST_IDLE) && fifo_empty;

endmodule
